// File: rtl/excp_flush_ctrl.sv
// rtl/excp_flush_ctrl.sv - exception/ertn flush sequencer and IF redirect controller
module excp_flush_ctrl #(
    parameter int DRAIN_MAX = 15,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wb_valid,
    input  logic             wb_ex,
    input  logic             wb_ertn,
    input  logic [31:0]      csr_eentry,
    input  logic [31:0]      csr_era,
    input  logic             ifetch_idle,
    input  logic             redirect_ready,
    output logic             flush,
    output logic             fetch_hold,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic             drain_timeout,
    output logic             req_dropped,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    // Last drain count value before giving up on IF going idle.
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

    state_t           state_q, state_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [7:0]       drain_cnt_q, drain_cnt_d;
    logic             drain_timeout_q, drain_timeout_d;
    logic             req_dropped_q, req_dropped_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             req;
    logic             accept;

    assign req    = wb_valid & (wb_ex | wb_ertn);
    assign accept = (state_q == ST_IDLE) & req;

    // Next-state and datapath updates for the flush / drain / redirect sequence.
    always_comb begin
        state_d         = state_q;
        redirect_pc_d   = redirect_pc_q;
        drain_cnt_d     = drain_cnt_q;
        drain_timeout_d = drain_timeout_q;
        req_dropped_d   = req_dropped_q;
        flush_cnt_d     = flush_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    // Exception takes priority over ertn when both are flagged.
                    redirect_pc_d = wb_ex ? csr_eentry : csr_era;
                    if (flush_cnt_q != {CNT_W{1'b1}}) begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                    drain_cnt_d = 8'd0;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (req) begin
                    req_dropped_d = 1'b1;
                end
                if (ifetch_idle) begin
                    state_d = ST_REDIR;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    // IF never went idle; redirect anyway and leave a sticky flag.
                    drain_timeout_d = 1'b1;
                    state_d         = ST_REDIR;
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
            end
            ST_REDIR: begin
                if (req) begin
                    req_dropped_d = 1'b1;
                end
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and status registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= ST_IDLE;
            redirect_pc_q   <= 32'd0;
            drain_cnt_q     <= 8'd0;
            drain_timeout_q <= 1'b0;
            req_dropped_q   <= 1'b0;
            flush_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            redirect_pc_q   <= redirect_pc_d;
            drain_cnt_q     <= drain_cnt_d;
            drain_timeout_q <= drain_timeout_d;
            req_dropped_q   <= req_dropped_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    // Flush is gated by reset so every output reads zero while reset is held.
    assign flush          = resetn & accept;
    assign fetch_hold     = (state_q != ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign redirect_valid = (state_q == ST_REDIR);
    assign redirect_pc    = redirect_pc_q;
    assign drain_timeout  = drain_timeout_q;
    assign req_dropped    = req_dropped_q;
    assign flush_cnt      = flush_cnt_q;

endmodule

// File: doc/excp_flush_ctrl.md
Name: excp_flush_ctrl

Overview:
- Sequences pipeline flush and front-end redirect when the writeback stage commits an exception or an ertn.
- Issues a same-cycle flush to all stages and captures the redirect target from the CSR file.
- Holds the fetch stage until any outstanding instruction request has drained, then hands IF a single redirect PC.
- Sits between WB / CSR and the IF stage.

Parameters:
- DRAIN_MAX, 15, cycles to wait in DRAIN before forcing redirect and flagging timeout. Valid range 1..255.
- CNT_W, 16, width of the saturating flush event counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- wb_valid  in  1  WB holds a valid instruction this cycle.
- wb_ex  in  1  WB instruction raises an exception.
- wb_ertn  in  1  WB instruction is ertn.
- csr_eentry  in  32  exception entry address from CSR.
- csr_era  in  32  exception return address from CSR.
- ifetch_idle  in  1  IF has no outstanding instruction-bus request.
- redirect_ready  in  1  IF accepts redirect_pc this cycle.
- flush  out  1  kill all IF/ID/EX/MEM contents; combinational.
- fetch_hold  out  1  IF must not issue new requests.
- redirect_valid  out  1  redirect_pc is valid.
- redirect_pc  out  32  new fetch address.
- busy  out  1  state != IDLE.
- drain_timeout  out  1  sticky: DRAIN exceeded DRAIN_MAX.
- req_dropped  out  1  sticky: request arrived while not IDLE.
- flush_cnt  out  CNT_W  number of accepted requests, saturating.

Behaviour:
- Reset (resetn=0, async): state=IDLE, redirect_pc=0, drain counter=0, drain_timeout=0, req_dropped=0, flush_cnt=0. All outputs 0.
- Request: req = wb_valid & (wb_ex | wb_ertn).
- Priority: wb_ex over wb_ertn when both are set.
- States: IDLE, DRAIN, REDIR.

IDLE:
- flush = req, combinational in the same cycle, so younger instructions are killed before they advance.
- On req:
  - redirect_pc <= wb_ex ? csr_eentry : csr_era, sampled this cycle.
  - flush_cnt increments unless it is all-ones.
  - drain counter <= 0.
  - Next state DRAIN.
- Otherwise stay in IDLE.

DRAIN:
- fetch_hold=1, flush=0.
- If ifetch_idle=1, go to REDIR. Minimum one DRAIN cycle even when IF is already idle.
- Else the counter increments. When the counter equals DRAIN_MAX-1 and ifetch_idle=0: set drain_timeout=1 (sticky) and go to REDIR.

REDIR:
- fetch_hold=1, redirect_valid=1, redirect_pc stable.
- Hold until redirect_ready=1, then go to IDLE in the next cycle.
- redirect_valid must not drop without the handshake.

Common rules:
- busy=1 in DRAIN and REDIR.
- Any req while in DRAIN or REDIR is ignored: no flush, target not overwritten, flush_cnt unchanged, req_dropped=1 (sticky).
- Latency with ifetch_idle=1 and redirect_ready=1: request at cycle T gives flush at T, DRAIN at T+1, redirect_valid at T+2, IDLE at T+3. A new request is accepted at T+3.
- Reset mid-operation: immediate return to IDLE. Outputs clear asynchronously and no redirect is issued.
- wb_ex or wb_ertn with wb_valid=0: no effect.

Test Plan:
- Exception, IF idle: wb_valid=1, wb_ex=1, csr_eentry=0x1C008000 at T, ifetch_idle=1, redirect_ready=1 -> flush=1 only at T; redirect_valid=1 with redirect_pc=0x1C008000 only at T+2; busy low at T+3; flush_cnt=1.
- ertn with slow drain: wb_ertn=1, csr_era=0x1C000104; ifetch_idle low for 3 cycles after T -> DRAIN lasts 3 cycles with fetch_hold=1; redirect_pc=0x1C000104; drain_timeout=0.
- Simultaneous wb_ex=1 and wb_ertn=1, eentry=0xA0, era=0xB0 -> redirect_pc=0xA0.
- Drain timeout: DRAIN_MAX=4, ifetch_idle held 0 -> REDIR entered after 4 DRAIN cycles; drain_timeout=1 and stays 1 through the next request.
- Back-pressure and drop: redirect_ready=0 for 5 cycles with a second req during REDIR -> redirect_valid and redirect_pc held for 5 cycles; no flush for the second req; req_dropped=1; flush_cnt unchanged.
- Async reset while in DRAIN: assert resetn=0 mid-cycle -> busy, fetch_hold and redirect_valid fall immediately; after release, state is IDLE and flush_cnt=0.
